// File: rtl/fft_stage_sequencer_pkg.sv
// Shared types and helpers for the radix-2 block-floating-point FFT stage sequencer.
package fft_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ISSUE,
    DRAIN,
    CAPTURE,
    DONE
  } seq_state_e;

  localparam logic [1:0] CTRL_FIRST = 2'b01;
  localparam logic [1:0] CTRL_LAST  = 2'b10;

  function automatic int BFLY_PER_STAGE(input int n);
    return 1 << (n - 1);
  endfunction

endpackage

// File: rtl/fft_stage_sequencer_if.sv
// Sequencer <-> butterfly unit connection: issue/control towards the butterfly, write-back status back.
interface fft_stage_sequencer_if #(
  parameter int FFT_N             = 10,
  parameter int FFT_MAX_BIT_WIDTH = 5
);
  localparam int AW = (FFT_N > 1) ? FFT_N - 1 : 1;

  logic                         iact;
  logic [1:0]                   ictrl;
  logic [AW-1:0]                MemAddr;
  logic [AW-1:0]                twiddleFactorAddr;
  logic                         evenOdd;
  logic                         ifft;
  logic                         clr_bfp;
  logic [FFT_MAX_BIT_WIDTH-1:0] ibfp;
  logic                         oact;
  logic [FFT_MAX_BIT_WIDTH-1:0] max_bit_width_current_FFT_stage;

  modport master (
    output iact, ictrl, MemAddr, twiddleFactorAddr, evenOdd, ifft, clr_bfp, ibfp,
    input  oact, max_bit_width_current_FFT_stage
  );

  modport slave (
    input  iact, ictrl, MemAddr, twiddleFactorAddr, evenOdd, ifft, clr_bfp, ibfp,
    output oact, max_bit_width_current_FFT_stage
  );
endinterface

// File: rtl/fft_stage_addr_gen.sv
// Registered butterfly read address, twiddle index and first/last flags from butterfly index k and stage.
module fft_stage_addr_gen
  import fft_pkg::*;
#(
  parameter int FFT_N = 10,
  parameter int AW    = 9,
  parameter int SW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [AW-1:0] k,
  input  logic [SW-1:0] stage,
  output logic [AW-1:0] mem_addr,
  output logic [AW-1:0] twiddle_addr,
  output logic [1:0]    ictrl
);
  localparam logic [AW-1:0] K_LAST = AW'(BFLY_PER_STAGE(FFT_N) - 1);

  // Each stage keeps one more high-order bit of k as the twiddle index.
  logic [AW-1:0] tw_mask;
  logic [1:0]    ictrl_next;

  always_comb begin
    tw_mask    = ~({AW{1'b1}} >> stage);
    ictrl_next = 2'b00;
    if (k == '0)     ictrl_next = ictrl_next | CTRL_FIRST;
    if (k == K_LAST) ictrl_next = ictrl_next | CTRL_LAST;
  end

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      mem_addr     <= '0;
      twiddle_addr <= '0;
      ictrl        <= 2'b00;
    end else begin
      mem_addr     <= k;
      twiddle_addr <= k & tw_mask;
      ictrl        <= ictrl_next;
    end
  end
endmodule

// File: rtl/fft_stage_sequencer.sv
// Radix-2 BFP FFT stage sequencer: issues butterflies per stage, waits for write-back, carries bit width forward.
// Optional FFT_STAGE_SEQ_BLKEXP_EN adds the block_exp output with its per-transform exponent accumulator.
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int FFT_N             = 10,
  parameter int FFT_DW            = 16,
  parameter int FFT_MAX_BIT_WIDTH = 5
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           start,
  input  logic                                           ifft_req,
  input  logic [FFT_MAX_BIT_WIDTH-1:0]                   ibfp_init,
  output logic                                           busy,
  output logic                                           done,
  output logic [((FFT_N > 1) ? $clog2(FFT_N) : 1)-1:0]   stage,
  output logic                                           seq_err,
`ifdef FFT_STAGE_SEQ_BLKEXP_EN
  output logic [$clog2(FFT_N*FFT_DW):0]                  block_exp,
`endif
  fft_stage_sequencer_if.master                          bf
);
  localparam int AW = (FFT_N > 1) ? FFT_N - 1 : 1;
  localparam int SW = (FFT_N > 1) ? $clog2(FFT_N) : 1;
  localparam int CW = FFT_N;
  localparam logic [CW-1:0] NB         = CW'(BFLY_PER_STAGE(FFT_N));
  localparam logic [AW-1:0] K_LAST     = AW'(BFLY_PER_STAGE(FFT_N) - 1);
  localparam logic [SW-1:0] LAST_STAGE = SW'(FFT_N - 1);

  seq_state_e               state_reg, state_next;
  logic [AW-1:0]            k_reg, k_next;
  logic [SW-1:0]            stage_reg, stage_next;
  logic [CW-1:0]            oact_cnt_reg, oact_cnt_next;
  logic                     seq_err_reg, seq_err_next;
  logic                     ignore_oact_reg, ignore_oact_next;
  logic                     busy_reg, done_reg, iact_reg, clr_bfp_reg, ifft_reg;
  logic [FFT_MAX_BIT_WIDTH-1:0] ibfp_reg;
  logic                     oact_extra, oact_count;

  always_comb begin
    state_next       = state_reg;
    k_next           = k_reg;
    stage_next       = stage_reg;
    oact_cnt_next    = oact_cnt_reg;
    seq_err_next     = seq_err_reg;
    ignore_oact_next = ignore_oact_reg;
    // Write-backs still in flight from an aborted run are swallowed until the next start.
    oact_extra = bf.oact && !ignore_oact_reg &&
                 (state_reg == IDLE || state_reg == CLEAR || oact_cnt_reg == NB);
    oact_count = bf.oact && (state_reg == ISSUE || state_reg == DRAIN) && (oact_cnt_reg != NB);
    if (oact_extra) seq_err_next = 1'b1;
    if (oact_count) oact_cnt_next = oact_cnt_reg + CW'(1);

    case (state_reg)
      IDLE: if (start) begin
        state_next       = CLEAR;
        stage_next       = '0;
        ignore_oact_next = 1'b0;
      end
      CLEAR: begin
        state_next    = ISSUE;
        k_next        = '0;
        oact_cnt_next = '0;
      end
      ISSUE: begin
        if (k_reg == K_LAST) state_next = DRAIN;
        else                 k_next     = k_reg + AW'(1);
      end
      DRAIN: if (oact_cnt_next == NB) state_next = CAPTURE;
      CAPTURE: begin
        if (stage_reg == LAST_STAGE) begin
          state_next = DONE;
        end else begin
          state_next = CLEAR;
          stage_next = stage_reg + SW'(1);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      k_reg           <= '0;
      stage_reg       <= '0;
      oact_cnt_reg    <= '0;
      seq_err_reg     <= 1'b0;
      ignore_oact_reg <= 1'b1;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      iact_reg        <= 1'b0;
      clr_bfp_reg     <= 1'b0;
      ifft_reg        <= 1'b0;
      ibfp_reg        <= '0;
    end else begin
      state_reg       <= state_next;
      k_reg           <= k_next;
      stage_reg       <= stage_next;
      oact_cnt_reg    <= oact_cnt_next;
      seq_err_reg     <= seq_err_next;
      ignore_oact_reg <= ignore_oact_next;
      busy_reg        <= (state_next != IDLE) && (state_next != DONE);
      done_reg        <= (state_next == DONE);
      iact_reg        <= (state_next == ISSUE);
      clr_bfp_reg     <= (state_next == CLEAR);
      if (state_reg == IDLE && start) begin
        ifft_reg <= ifft_req;
        ibfp_reg <= ibfp_init;
      end else if (state_reg == CAPTURE) begin
        ibfp_reg <= bf.max_bit_width_current_FFT_stage;
      end
    end
  end

`ifdef FFT_STAGE_SEQ_BLKEXP_EN
  localparam int BEW = $clog2(FFT_N*FFT_DW) + 1;
  localparam logic [FFT_MAX_BIT_WIDTH-1:0] HEADROOM = FFT_MAX_BIT_WIDTH'(FFT_DW - 2);
  logic [BEW-1:0] block_exp_reg;

  // Growth beyond the headroom threshold in each stage becomes exponent.
  always_ff @(posedge clk) begin
    if (reset) begin
      block_exp_reg <= '0;
    end else if (state_reg == IDLE && start) begin
      block_exp_reg <= '0;
    end else if (state_reg == CAPTURE && bf.max_bit_width_current_FFT_stage > HEADROOM) begin
      block_exp_reg <= block_exp_reg + BEW'(bf.max_bit_width_current_FFT_stage - HEADROOM);
    end
  end

  assign block_exp = block_exp_reg;
`endif

  fft_stage_addr_gen #(.FFT_N(FFT_N), .AW(AW), .SW(SW)) u_addr_gen (
    .clk          (clk),
    .reset        (reset),
    .en           (state_next == ISSUE),
    .k            (k_next),
    .stage        (stage_next),
    .mem_addr     (bf.MemAddr),
    .twiddle_addr (bf.twiddleFactorAddr),
    .ictrl        (bf.ictrl)
  );

  assign busy       = busy_reg;
  assign done       = done_reg;
  assign stage      = stage_reg;
  assign seq_err    = seq_err_reg;
  assign bf.iact    = iact_reg;
  assign bf.clr_bfp = clr_bfp_reg;
  assign bf.ifft    = ifft_reg;
  assign bf.ibfp    = ibfp_reg;
  assign bf.evenOdd = stage_reg[0];
endmodule
